// File: rtl/atc_pkg.sv
// Shared constants and helpers for the approximate tree compressor
// error-recovery block.
package atc_pkg;

   localparam int ATC_WORD_SIZE = 11;
   localparam int ATC_CNT_W     = 16;
   localparam int ATC_SUM_W     = ATC_WORD_SIZE + 2;

   function automatic int atc_clamp_lvl(input int lvl, input int ws);
      return (lvl > ws) ? ws : lvl;
   endfunction

endpackage

// File: rtl/atc_rec_mask.sv
// Recovery mask: selects the L most significant bits of the error vector.
// Purely combinational.
module atc_rec_mask
   import atc_pkg::*;
#(
   parameter int WORD_SIZE = ATC_WORD_SIZE,
   parameter int LW        = $clog2(WORD_SIZE + 1)
) (
   input  logic [LW-1:0]        l,
   output logic [WORD_SIZE-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < WORD_SIZE; i++) begin
         mask[i] = (i >= (WORD_SIZE - int'(l)));
      end
   end

endmodule

// File: rtl/atc_err_recover.sv
// Two-stage error-recovery adder with valid/ready handshake and a
// saturating count of corrected transactions.
module atc_err_recover
   import atc_pkg::*;
#(
   parameter int WORD_SIZE = ATC_WORD_SIZE,
   parameter int CNT_W     = ATC_CNT_W,
   localparam int SUM_W    = WORD_SIZE + 2,
   localparam int LW       = $clog2(WORD_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] p0,
   input  logic [WORD_SIZE-1:0] p1,
   input  logic [WORD_SIZE-1:0] v,
   input  logic [LW-1:0]        rec_lvl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SUM_W-1:0]     sum,
   output logic [CNT_W-1:0]     err_cnt,
   input  logic                 clr_cnt
);

   logic [LW-1:0]        lvl_c;
   logic [WORD_SIZE-1:0] mask;
   logic [WORD_SIZE-1:0] v_m;
   logic                 s2_load;
   logic                 s1_load;
   logic                 accept;

   logic                 s1_valid_q, s1_valid_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [SUM_W-1:0]     s1_pp_q, s1_pp_d;
   logic [SUM_W-1:0]     s1_corr_q, s1_corr_d;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   assign lvl_c = LW'(atc_clamp_lvl(int'(rec_lvl), WORD_SIZE));

   atc_rec_mask #(
      .WORD_SIZE (WORD_SIZE),
      .LW        (LW)
   ) u_mask (
      .l    (lvl_c),
      .mask (mask)
   );

   assign v_m     = v & mask;
   assign s2_load = !s2_valid_q || out_ready;
   assign s1_load = !s1_valid_q || s2_load;
   assign accept  = in_valid && s1_load;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_pp_d    = s1_pp_q;
      s1_corr_d  = s1_corr_q;
      s2_valid_d = s2_valid_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      if (s1_load) begin
         s1_valid_d = accept;
      end
      if (accept) begin
         s1_pp_d   = SUM_W'(p0) + SUM_W'(p1);
         s1_corr_d = SUM_W'(v_m) << 1;
      end
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            sum_d = s1_pp_q + s1_corr_q;
         end
      end
      // Clear takes priority over a same-cycle correction event.
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (accept && (|v_m) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_pp_q    <= '0;
         s1_corr_q  <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_pp_q    <= s1_pp_d;
         s1_corr_q  <= s1_corr_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = s1_load;
   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_atc_err_recover.sv
// Directed and randomized checks of atc_err_recover against a
// queue-based reference model.
module tb_atc_err_recover;

   localparam int WS = 11;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [WS-1:0] p0, p1, v;
   logic [LW-1:0] rec_lvl;
   logic          out_ready;
   logic          clr_cnt;

   logic          in_ready, out_valid;
   logic [WS+1:0] sum;
   logic [15:0]   err_cnt;
   logic          in_ready_b, out_valid_b;
   logic [WS+1:0] sum_b;
   logic [3:0]    err_cnt_b;

   int checks = 0;
   int errors = 0;
   int q[$];
   int cnt_m;
   int cnt_mb;
   bit last_acc;

   always #5 clk = ~clk;

   atc_err_recover #(.WORD_SIZE(WS), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .p0(p0), .p1(p1), .v(v), .rec_lvl(rec_lvl),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .err_cnt(err_cnt), .clr_cnt(clr_cnt)
   );

   atc_err_recover #(.WORD_SIZE(WS), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .p0(p0), .p1(p1), .v(v), .rec_lvl(rec_lvl),
      .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
      .err_cnt(err_cnt_b), .clr_cnt(clr_cnt)
   );

   // Correction term from the rule: MSB-side L bits of v, doubled.
   function automatic int corr_of(int vv, int lvl);
      int l = (lvl > WS) ? WS : lvl;
      int c = 0;
      for (int i = 0; i < WS; i++)
         if (i >= WS - l && ((vv >> i) & 1) == 1) c += 2 ** (i + 1);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at posedge+1; this samples mid-cycle, steps one edge,
   // updates the model, and returns at posedge+1.
   task automatic tick();
      bit exp_ir, acc, oh;
      int c;
      #3;
      exp_ir = (q.size() < 2) || out_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("in_ready_b", 32'(in_ready_b), 32'(exp_ir));
      if (out_valid) begin
         chk("out_pending", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) chk("sum", 32'(sum), q[0]);
      end
      if (out_valid_b && q.size() != 0) chk("sum_b", 32'(sum_b), q[0]);
      acc = in_valid && exp_ir;
      oh  = out_valid && out_ready;
      c   = corr_of(int'(v), int'(rec_lvl));
      @(posedge clk);
      if (oh && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(int'(p0) + int'(p1) + c);
      if (clr_cnt) begin
         cnt_m  = 0;
         cnt_mb = 0;
      end else if (acc && c != 0) begin
         if (cnt_m < 65535) cnt_m++;
         if (cnt_mb < 15) cnt_mb++;
      end
      #1;
      chk("err_cnt", 32'(err_cnt), cnt_m);
      chk("err_cnt_b", 32'(err_cnt_b), cnt_mb);
      last_acc = acc;
   endtask

   task automatic drive(input bit iv, input int a, input int b,
                        input int vv, input int lv);
      in_valid = iv;
      p0       = WS'(a);
      p1       = WS'(b);
      v        = WS'(vv);
      rec_lvl  = LW'(lv);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && q.size() != 0; k++) tick();
      chk("drained", 32'(q.size()), 32'd0);
   endtask

   int seq_p0[8];
   int seq_p1[8];
   int seq_v[8];
   int seq_l[8];

   initial begin
      rst = 1'b1; clr_cnt = 1'b0; out_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 0);
      cnt_m = 0; cnt_mb = 0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      // Single correcting transaction, latency of two edges.
      drive(1'b1, 'h005, 'h003, 'h400, 1);
      tick();
      chk("lat_edge1_valid", 32'(out_valid), 32'd0);
      drive(1'b0, 0, 0, 0, 0);
      out_ready = 1'b0;
      tick();
      chk("lat_edge2_valid", 32'(out_valid), 32'd1);
      chk("sum_808", 32'(sum), 32'h808);
      chk("cnt_1", 32'(err_cnt), 32'd1);
      drain();

      drive(1'b1, 'h005, 'h003, 'h400, 0);
      tick();
      drive(1'b0, 0, 0, 0, 0);
      tick();
      chk("sum_008", 32'(sum), 32'h008);
      chk("cnt_unchanged", 32'(err_cnt), 32'd1);
      drain();

      drive(1'b1, 'h7FF, 'h7FF, 'h7FF, 15);
      tick();
      drive(1'b0, 0, 0, 0, 0);
      tick();
      chk("sum_1ffc", 32'(sum), 32'h1FFC);
      drain();

      // Eight back-to-back with five stalled cycles at the output.
      for (int i = 0; i < 8; i++) begin
         seq_p0[i] = int'($urandom_range(0, 2047));
         seq_p1[i] = int'($urandom_range(0, 2047));
         seq_v[i]  = int'($urandom_range(0, 2047));
         seq_l[i]  = int'($urandom_range(0, 15));
      end
      begin
         int idx = 0;
         int cyc = 0;
         out_ready = 1'b0;
         while (idx < 8 && cyc < 40) begin
            out_ready = (cyc >= 5);
            drive(1'b1, seq_p0[idx], seq_p1[idx], seq_v[idx], seq_l[idx]);
            tick();
            if (cyc == 4) chk("stall_full_ready", 32'(in_ready), 32'd0);
            if (cyc == 4) chk("stall_accepts", 32'(idx + int'(last_acc)), 32'd2);
            if (last_acc) idx++;
            cyc++;
         end
         chk("stream_all_accepted", 32'(idx), 32'd8);
      end
      drain();

      // Saturation on the narrow counter, then clear beating an increment.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, i, 1, 'h400, 11);
         tick();
      end
      chk("sat_b", 32'(err_cnt_b), 32'd15);
      drive(1'b1, 1, 1, 'h7FF, 11);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("clr_wins", 32'(err_cnt), 32'd0);
      chk("clr_wins_b", 32'(err_cnt_b), 32'd0);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 15)));
         out_ready = $urandom_range(0, 3) != 0;
         clr_cnt   = $urandom_range(0, 15) == 0;
         tick();
      end
      clr_cnt = 1'b0;
      drain();

      // Reset with two transactions in flight.
      out_ready = 1'b0;
      drive(1'b1, 'h123, 'h456, 'h7FF, 11);
      tick();
      tick();
      chk("two_in_flight", 32'(q.size()), 32'd2);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_sum", 32'(sum), 32'd0);
      chk("rst_mid_cnt", 32'(err_cnt), 32'd0);
      q.delete();
      cnt_m = 0; cnt_mb = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 0, 0, 0, 0);
      out_ready = 1'b1;
      chk("ready_after_mid_rst", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stale_valid", 32'(out_valid), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/atc_err_recover.md
ATC_ERR_RECOVER -- requirements
Module: atc_err_recover

Interface
REQ-001 Parameter WORD_SIZE, default 11: width of each compressed row and of the error vector.
REQ-002 Parameter CNT_W, default 16: width of the error-event counter.
REQ-003 The clock and reset ports SHALL be exactly as decided: one clock, reset asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  p0/p1/v/rec_lvl hold a valid transaction.
REQ-007 in_ready  output  1  block accepts a transaction this cycle.
REQ-008 p0  input  WORD_SIZE  compressed row 0 from the approximate tree compressor.
REQ-009 p1  input  WORD_SIZE  compressed row 1 from the approximate tree compressor.
REQ-010 v  input  WORD_SIZE  error vector, the OR of the compressor carry rows.
REQ-011 rec_lvl  input  $clog2(WORD_SIZE+1)  recovery level, the number of V MSBs to correct.
REQ-012 out_valid  output  1  sum is valid.
REQ-013 out_ready  input  1  downstream accepts sum.
REQ-014 sum  output  WORD_SIZE+2  recovered result.
REQ-015 err_cnt  output  CNT_W  count of transactions in which a correction was applied.
REQ-016 clr_cnt  input  1  synchronous clear of err_cnt.

Function
REQ-017 A transaction SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-018 Recovery mask: bit i is set iff i >= WORD_SIZE - L, where L = min(rec_lvl, WORD_SIZE).
REQ-019 Result: sum = p0 + p1 + ((v & mask) << 1), computed at WORD_SIZE+2 bits; this width never overflows.
REQ-020 rec_lvl SHALL be sampled with its transaction; later changes do not affect transactions already in flight.
REQ-021 Pipeline: two register stages. Stage 1 registers p0+p1 and the masked, shifted correction. Stage 2 registers the final sum.
REQ-022 Latency: sum is presented with out_valid on the 2nd rising edge after acceptance when there is no stall.
REQ-023 Throughput: one transaction per cycle while out_ready=1.
REQ-024 Stage advance: stage 2 loads when !s2_valid || out_ready. Stage 1 loads when !s1_valid || stage 2 loads.
REQ-025 in_ready SHALL equal !s1_valid || (!s2_valid || out_ready).
REQ-026 Stall: while out_valid && !out_ready, sum SHALL hold stable. No transaction is dropped or duplicated, and ordering is preserved.
REQ-027 Pipeline full (both stages valid, out_ready=0): in_ready=0.
REQ-028 Simultaneous out handshake and in handshake in the same cycle: both SHALL complete and the pipeline SHALL stay full.
REQ-029 err_cnt SHALL increment by 1 at acceptance when (v & mask) != 0, and saturate at 2^CNT_W-1.
REQ-030 When clr_cnt is high, err_cnt SHALL be 0 next cycle. clr_cnt wins over a simultaneous increment.

Reset
REQ-031 While rst=1 (asynchronous): out_valid=0, both stage valid flags=0, sum=0, err_cnt=0.
REQ-032 Reset mid-operation SHALL discard all in-flight transactions. in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-033 Package atc_pkg SHALL hold the WORD_SIZE default, CNT_W default, and the sum width constant WORD_SIZE+2.
REQ-034 Mask generation SHALL be a sub-module atc_rec_mask (inputs L, output WORD_SIZE-bit mask, combinational).
REQ-035 The pipeline and the counter SHALL live in atc_err_recover.

Verification
REQ-036 Stimulus p0=0x005, p1=0x003, v=0x400, rec_lvl=1, out_ready=1 -> sum=0x808 two edges later, err_cnt=1.
REQ-037 Stimulus p0=0x005, p1=0x003, v=0x400, rec_lvl=0 -> sum=0x008, err_cnt unchanged.
REQ-038 Stimulus p0=p1=v=0x7FF, rec_lvl=15 (clamped to 11) -> sum=0x1FFC.
REQ-039 Stream of 8 back-to-back transactions with out_ready held 0 for 5 cycles -> in_ready=0 after 2 accepts, sum held stable, and all 8 results delivered in order.
REQ-040 err_cnt preset to 0xFFFF with a correcting transaction -> stays 0xFFFF. clr_cnt asserted with a simultaneous correcting accept -> err_cnt=0.
REQ-041 rst asserted with 2 transactions in flight -> out_valid=0 immediately, and no stale sum appears after release.
